toggle_bank: RTL and testbench
==============================

# toggle_bank

Bank of WIDTH independent toggle (T) flip-flops sharing one clock and one asynchronous active-low reset. Each output bit inverts on a rising clock edge when its toggle input is 1 and holds otherwise. Synchronous clear and parallel load are provided for control logic. The block is a leaf primitive for dividers, parity trackers and state flags; its ports are intended to be bundled in a design-side modport (inputs clk, rst, t; output q).

## Interface
Parameters:
- WIDTH, 1: number of toggle flops (≥1).
- CNT_W, 16: width of the toggle-event counter (used only with TOGGLE_BANK_CNT_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; 0 forces all state to reset values immediately.
- t  input  WIDTH  per-bit toggle request; 1 inverts that bit at the next clk rise.
- clr  input  1  synchronous clear; 1 loads all q bits with 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value written to q when load=1.
- q  output  WIDTH  registered flop state.
- toggle_cnt  output  CNT_W  number of clock edges on which at least one bit toggled (tied 0 without the macro).

## Operation
- One register per bit; q is driven directly from the registers (no combinational path from any input to q).
- On each rising clk edge with rst=1, priority:
  - clr=1: q <= 0.
  - else load=1: q <= load_val.
  - else: q <= q ^ t (bit i inverts iff t[i]=1, otherwise holds).
- An edge counts as a toggle event only in the third case, and only when t≠0.
- t=0 on all bits, clr=0, load=0: q holds indefinitely.
- X/Z on t is not supported; the bench drives only 0/1.

## Timing
- Reset: rst=0 asynchronously forces q=0 and toggle_cnt=0, independent of clk; state is held at 0 while rst=0.
- Reset release: the first rising clk edge with rst=1 is the first functional edge. rst must deassert at least one setup time before that edge; release synchronization is the integrator's responsibility.
- Latency: one cycle. t, clr, load and load_val are sampled at a clk rise, and q updates after that edge.
- Reset asserted mid-operation overrides any pending toggle, clear or load on the same edge.
- clr and load asserted together: clr wins and q=0.
- Changes to t between clk edges have no effect.

## Configuration
- Macro TOGGLE_BANK_CNT_EN.
- Defined:
  - toggle_cnt is a CNT_W-bit register that increments by 1 on every toggle event.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - It clears on rst=0 and on clr=1. It is not affected by load.
- Undefined: no counter logic is compiled in and toggle_cnt is driven constant 0.

## Test plan
- Reset: WIDTH=1, clk period 10, rst=0 from time 0 to 10, t=1 → q=0 throughout, including across the clk rise at 5.
- Toggle: WIDTH=1, rst=1 from 10, t=1 → q=1, 0, 1 after the rises at 15, 25, 35.
- Hold: continuing from the toggle test, t=0 from 40 → q stays 1 at 45, 55, 65, 75, 85.
- Async reset mid-run: rst driven 0 between edges while q=1 → q=0 immediately without a clk edge; q stays 0 until rst=1.
- Priority: WIDTH=4, q=4'b1010, t=4'b1111 with load=1, load_val=4'b0110 → q=4'b0110 after the edge; the same edge with clr=1 also asserted → q=4'b0000.
- Counter (macro defined, CNT_W=2): t≠0 for 5 consecutive edges → toggle_cnt reads 1, 2, 3, 3, 3; then clr=1 for one edge → toggle_cnt=0.

Source files
------------

// File: rtl/toggle_bank.sv
`default_nettype none
// ============================================================================
// Module   : toggle_bank
// Purpose  : Bank of WIDTH independent toggle flip-flops with synchronous
//            clear, synchronous parallel load and asynchronous active-low
//            reset. When the macro TOGGLE_BANK_CNT_EN is defined, a saturating
//            CNT_W-bit counter of toggle events is compiled in. Otherwise
//            toggle_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_bank #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic [WIDTH-1:0] q_reg;

  // Flop state: clear beats load, and load beats toggle. A t bit of 0 holds that bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= load_val;
    end else begin
      q_reg <= q_reg ^ t;
    end
  end

  // q comes straight from the flops, so there is no combinational path from any input.
  assign q = q_reg;

`ifdef TOGGLE_BANK_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             toggle_event;
  logic [CNT_W-1:0] cnt_reg;

  // An edge counts only when the toggle path is selected and some bit actually inverts.
  assign toggle_event = !clr && !load && (|t);

  // Saturating event counter. It clears with the bank and is not affected by load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (toggle_event && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign toggle_cnt = cnt_reg;
`else
  assign toggle_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_toggle_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_bank
// Purpose  : Self-checking bench for toggle_bank (WIDTH=4, CNT_W=2). It
//            compares the DUT against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_bank;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] t;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] toggle_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state, held as plain integers
  int model_q   = 0;
  int model_cnt = 0;

  toggle_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .t          (t),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .q          (q),
    .toggle_cnt (toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_cnt();
`ifdef TOGGLE_BANK_CNT_EN
    return model_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"}, int'(q), model_q);
    check({tag, ".cnt"}, int'(toggle_cnt), exp_cnt());
  endtask

  // Reference behaviour for one functional clock edge
  task automatic model_edge(input int tv, input int cl, input int ld, input int lv);
    if (cl != 0) begin
      model_q   = 0;
      model_cnt = 0;
    end else if (ld != 0) begin
      model_q = lv;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (((tv >> i) & 1) == 1) model_q = model_q ^ (1 << i);
      if (tv != 0 && model_cnt < CNT_SAT) model_cnt = model_cnt + 1;
    end
  endtask

  // Drive the inputs at a falling edge, clock once, then check 1 time unit after the rise.
  task automatic step(input string tag, input logic [WIDTH-1:0] tv, input logic cl,
                      input logic ld, input logic [WIDTH-1:0] lv);
    t = tv; clr = cl; load = ld; load_val = lv;
    @(posedge clk);
    model_edge(int'(tv), int'(cl), int'(ld), int'(lv));
    #1;
    check_model(tag);
    @(negedge clk);
  endtask

  initial begin
    // Reset held from time 0 while t requests a toggle
    rst = 1'b0; t = 4'b1111; clr = 1'b0; load = 1'b0; load_val = '0;
    #1;
    check("reset_t1.q", int'(q), 0);
    check("reset_t1.cnt", int'(toggle_cnt), 0);
    @(posedge clk); #1;
    check("reset_edge.q", int'(q), 0);
    @(negedge clk);
    rst = 1'b1;

    // Toggle bit 0 three times
    step("tog1", 4'b0001, 1'b0, 1'b0, 4'b0000); check("tog1_lit", int'(q), 1);
    step("tog2", 4'b0001, 1'b0, 1'b0, 4'b0000); check("tog2_lit", int'(q), 0);
    step("tog3", 4'b0001, 1'b0, 1'b0, 4'b0000); check("tog3_lit", int'(q), 1);

    // Hold across five edges
    for (int i = 0; i < 5; i++) begin
      step("hold", 4'b0000, 1'b0, 1'b0, 4'b0000);
      check("hold_lit", int'(q), 1);
    end

    // An asynchronous reset between edges clears q at once
    t = 4'b1111;
    #2 rst = 1'b0;
    #1;
    model_q = 0; model_cnt = 0;
    check("async_rst.q", int'(q), 0);
    check("async_rst.cnt", int'(toggle_cnt), 0);
    @(posedge clk); #1;
    check("async_hold.q", int'(q), 0);
    @(negedge clk);
    rst = 1'b1;

    // Priority: load beats toggle, and clear beats load
    step("pre_load", 4'b0000, 1'b0, 1'b1, 4'b1010);
    step("load_pri", 4'b1111, 1'b0, 1'b1, 4'b0110); check("load_pri_lit", int'(q), 6);
    step("pre_load2", 4'b0000, 1'b0, 1'b1, 4'b1010);
    step("clr_pri", 4'b1111, 1'b1, 1'b1, 4'b0110); check("clr_pri_lit", int'(q), 0);

    // Counter saturation over five toggle edges, followed by a clear
    step("cnt1", 4'b0011, 1'b0, 1'b0, 4'b0000);
    step("cnt2", 4'b1000, 1'b0, 1'b0, 4'b0000);
    step("cnt3", 4'b0101, 1'b0, 1'b0, 4'b0000);
    step("cnt4", 4'b1111, 1'b0, 1'b0, 4'b0000);
    step("cnt5", 4'b0010, 1'b0, 1'b0, 4'b0000);
`ifdef TOGGLE_BANK_CNT_EN
    check("cnt_sat_lit", int'(toggle_cnt), 3);
`endif
    step("cnt_clr", 4'b1111, 1'b1, 1'b0, 4'b0000);
    check("cnt_clr_lit", int'(toggle_cnt), 0);

    // A load does not disturb the counter
    step("cnt_a", 4'b0001, 1'b0, 1'b0, 4'b0000);
    step("cnt_ld", 4'b1111, 1'b0, 1'b1, 4'b1001);

    // Toggle requests that change between edges have no effect
    t = 4'b0000;
    #2 t = 4'b1111;
    #2 t = 4'b0000;
    step("glitch", 4'b0000, 1'b0, 1'b0, 4'b0000);

    // Randomised operation
    for (int n = 0; n < 300; n++) begin
      logic [WIDTH-1:0] rt, rlv;
      logic rc, rl;
      rt  = WIDTH'($urandom);
      rlv = WIDTH'($urandom);
      rc  = ($urandom_range(0, 9) == 0);
      rl  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) rt = '0;
      step("rand", rt, rc, rl, rlv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
